// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, operand-B select,
// jump conditions, forwarding selects and CCR bit positions.
package ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_NOT   = 4'd4,
    ALU_INC   = 4'd5,
    ALU_DEC   = 4'd6,
    ALU_SHL   = 4'd7,
    ALU_SHR   = 4'd8,
    ALU_PASSB = 4'd9,
    ALU_PASSA = 4'd10,
    ALU_NOP   = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_RSRC = 2'd0,
    SRC_DATA = 2'd1,
    SRC_HASH = 2'd2,
    SRC_SHMT = 2'd3
  } alu_src_e;

  typedef enum logic [1:0] {
    JMP_ALWAYS = 2'd0,
    JMP_Z      = 2'd1,
    JMP_N      = 2'd2,
    JMP_C      = 2'd3
  } jmp_sel_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RSVD = 2'd3
  } fwd_sel_e;

  localparam int unsigned CCR_Z   = 0;
  localparam int unsigned CCR_N   = 1;
  localparam int unsigned CCR_C   = 2;
  localparam int unsigned CCR_OVF = 3;

endpackage

// File: rtl/ex_alu.sv
// Combinational 16-bit ALU. Returns the result, candidate flags {OVF,C,N,Z}
// and a per-flag update mask telling the CCR which flags this op may touch.
module ex_alu
  import ex_stage_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  op,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic [3:0]  upd
);

  logic [16:0] ext;
  alu_op_e     op_e;

  assign op_e = alu_op_e'(op);

  always_comb begin
    ext    = '0;
    result = '0;
    flags  = '0;
    upd    = '0;
    unique case (op_e)
      ALU_ADD: begin
        ext            = {1'b0, a} + {1'b0, b};
        result         = ext[15:0];
        flags[CCR_C]   = ext[16];
        flags[CCR_OVF] = (a[15] == b[15]) && (ext[15] != a[15]);
        upd            = '1;
      end
      ALU_SUB: begin
        ext            = {1'b0, a} - {1'b0, b};
        result         = ext[15:0];
        flags[CCR_C]   = ext[16];
        flags[CCR_OVF] = (a[15] != b[15]) && (ext[15] != a[15]);
        upd            = '1;
      end
      ALU_AND: begin
        result = a & b;
        upd    = 4'b0011;
      end
      ALU_OR: begin
        result = a | b;
        upd    = 4'b0011;
      end
      ALU_NOT: begin
        result = ~a;
        upd    = 4'b0011;
      end
      ALU_INC: begin
        ext            = {1'b0, a} + 17'd1;
        result         = ext[15:0];
        flags[CCR_C]   = ext[16];
        flags[CCR_OVF] = ~a[15] & ext[15];
        upd            = '1;
      end
      ALU_DEC: begin
        ext            = {1'b0, a} - 17'd1;
        result         = ext[15:0];
        flags[CCR_C]   = ext[16];
        flags[CCR_OVF] = a[15] & ~ext[15];
        upd            = '1;
      end
      // Shifts run through a 17-bit window so the bit shifted out lands in
      // a fixed position (bit 16 for left, bit 0 for right).
      ALU_SHL: begin
        ext         = {1'b0, a} << b[3:0];
        result      = ext[15:0];
        flags[CCR_C] = ext[16];
        upd         = {1'b0, |b[3:0], 2'b11};
      end
      ALU_SHR: begin
        ext          = {a, 1'b0} >> b[3:0];
        result       = ext[16:1];
        flags[CCR_C] = ext[0];
        upd          = {1'b0, |b[3:0], 2'b11};
      end
      ALU_PASSB: result = b;
      ALU_PASSA: result = a;
      default:   result = '0;
    endcase
    flags[CCR_Z] = (result == '0);
    flags[CCR_N] = result[15];
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand selection, ALU, registered CCR and jump resolution.
// Optional operand forwarding is compiled in with `define EX_FWD_EN.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] PC_in,
  input  logic [3:0]  Shmt_in,
  input  logic [3:0]  hash_imm_in,
  input  logic [15:0] Data_in,
  input  logic [15:0] Rdst_val_in,
  input  logic [15:0] Rsrc_val_in,
  input  logic [1:0]  ALU_src1_in,
  input  logic [3:0]  ALU_OP_in,
  input  logic        set_Z_in,
  input  logic        clr_Z_in,
  input  logic        set_N_in,
  input  logic        clr_N_in,
  input  logic        set_C_in,
  input  logic        clr_C_in,
  input  logic        set_OVF_in,
  input  logic        clr_OVF_in,
  input  logic [1:0]  jmp_sel_in,
  input  logic        is_jmp_in,
  input  logic        jmp_src_in,
  input  logic        flags_restore,
  input  logic [3:0]  flags_restore_val,
`ifdef EX_FWD_EN
  input  logic [1:0]  fwd_a_sel,
  input  logic [1:0]  fwd_b_sel,
  input  logic [15:0] mem_fwd_val,
  input  logic [15:0] wb_fwd_val,
`endif
  output logic [15:0] alu_result,
  output logic [3:0]  ccr,
  output logic        jmp_taken,
  output logic [31:0] jmp_target,
  output logic        flush
);

  logic [15:0] op_a;
  logic [15:0] rsrc_eff;
  logic [15:0] op_b;
  logic [3:0]  alu_flags;
  logic [3:0]  alu_upd;
  logic [3:0]  ccr_q;
  logic [3:0]  ccr_next;
  logic [3:0]  set_vec;
  logic [3:0]  clr_vec;
  logic [3:0]  jmp_clr;
  logic        cond;

`ifdef EX_FWD_EN
  always_comb begin
    case (fwd_sel_e'(fwd_a_sel))
      FWD_MEM: op_a = mem_fwd_val;
      FWD_WB:  op_a = wb_fwd_val;
      default: op_a = Rdst_val_in;
    endcase
    case (fwd_sel_e'(fwd_b_sel))
      FWD_MEM: rsrc_eff = mem_fwd_val;
      FWD_WB:  rsrc_eff = wb_fwd_val;
      default: rsrc_eff = Rsrc_val_in;
    endcase
  end
`else
  assign op_a     = Rdst_val_in;
  assign rsrc_eff = Rsrc_val_in;
`endif

  always_comb begin
    case (alu_src_e'(ALU_src1_in))
      SRC_RSRC: op_b = rsrc_eff;
      SRC_DATA: op_b = Data_in;
      SRC_HASH: op_b = {12'b0, hash_imm_in};
      default:  op_b = {12'b0, Shmt_in};
    endcase
  end

  ex_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (ALU_OP_in),
    .result (alu_result),
    .flags  (alu_flags),
    .upd    (alu_upd)
  );

  // Conditions look at the registered CCR only, never same-cycle ALU flags.
  always_comb begin
    jmp_clr = '0;
    case (jmp_sel_e'(jmp_sel_in))
      JMP_Z:   cond = ccr_q[CCR_Z];
      JMP_N:   cond = ccr_q[CCR_N];
      JMP_C:   cond = ccr_q[CCR_C];
      default: cond = 1'b1;
    endcase
    jmp_taken = is_jmp_in & cond;
    if (jmp_taken) begin
      case (jmp_sel_e'(jmp_sel_in))
        JMP_Z:   jmp_clr[CCR_Z] = 1'b1;
        JMP_N:   jmp_clr[CCR_N] = 1'b1;
        JMP_C:   jmp_clr[CCR_C] = 1'b1;
        default: jmp_clr = '0;
      endcase
    end
  end

  assign flush      = jmp_taken;
  assign jmp_target = jmp_src_in ? (PC_in + 32'd1) : {16'b0, Rdst_val_in};

  assign set_vec = {set_OVF_in, set_C_in, set_N_in, set_Z_in};
  assign clr_vec = {clr_OVF_in, clr_C_in, clr_N_in, clr_Z_in};

  always_comb begin
    ccr_next = ccr_q;
    if (flags_restore) begin
      ccr_next = flags_restore_val;
    end else if (!stall) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (clr_vec[i])      ccr_next[i] = 1'b0;
        else if (set_vec[i]) ccr_next[i] = 1'b1;
        else if (jmp_clr[i]) ccr_next[i] = 1'b0;
        else if (alu_upd[i]) ccr_next[i] = alu_flags[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ccr_q <= '0;
    else       ccr_q <= ccr_next;
  end

  assign ccr = ccr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: an integer reference model predicts each
// cycle's combinational outputs and the next CCR value.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] PC_in;
  logic [3:0]  Shmt_in, hash_imm_in, ALU_OP_in;
  logic [15:0] Data_in, Rdst_val_in, Rsrc_val_in;
  logic [1:0]  ALU_src1_in, jmp_sel_in;
  logic        set_Z_in, clr_Z_in, set_N_in, clr_N_in;
  logic        set_C_in, clr_C_in, set_OVF_in, clr_OVF_in;
  logic        is_jmp_in, jmp_src_in, flags_restore;
  logic [3:0]  flags_restore_val;
  logic [15:0] alu_result;
  logic [3:0]  ccr;
  logic        jmp_taken, flush;
  logic [31:0] jmp_target;
`ifdef EX_FWD_EN
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] mem_fwd_val, wb_fwd_val;
`endif

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .PC_in(PC_in), .Shmt_in(Shmt_in),
    .hash_imm_in(hash_imm_in), .Data_in(Data_in), .Rdst_val_in(Rdst_val_in),
    .Rsrc_val_in(Rsrc_val_in), .ALU_src1_in(ALU_src1_in), .ALU_OP_in(ALU_OP_in),
    .set_Z_in(set_Z_in), .clr_Z_in(clr_Z_in), .set_N_in(set_N_in), .clr_N_in(clr_N_in),
    .set_C_in(set_C_in), .clr_C_in(clr_C_in), .set_OVF_in(set_OVF_in),
    .clr_OVF_in(clr_OVF_in), .jmp_sel_in(jmp_sel_in), .is_jmp_in(is_jmp_in),
    .jmp_src_in(jmp_src_in), .flags_restore(flags_restore),
    .flags_restore_val(flags_restore_val),
`ifdef EX_FWD_EN
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
`endif
    .alu_result(alu_result), .ccr(ccr), .jmp_taken(jmp_taken),
    .jmp_target(jmp_target), .flush(flush)
  );

  typedef struct {
    logic        reset, stall, restore, is_jmp, jsrc;
    logic [3:0]  rval, setv, clrv, op, shmt, hash;
    logic [1:0]  src, jsel, fa, fb;
    logic [15:0] rdst, rsrc, data, memv, wbv;
    logic [31:0] pc;
  } stim_t;

  typedef struct {
    logic [15:0] res;
    logic        taken;
    logic [31:0] tgt;
  } comb_exp_t;

  comb_exp_t  comb_q[$];
  logic [3:0] ccr_q[$];
  logic [3:0] mccr = 4'b0000;
  int         checks = 0;
  int         errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{reset: 1'b0, stall: 1'b0, restore: 1'b0, is_jmp: 1'b0, jsrc: 1'b0,
          rval: 4'h0, setv: 4'h0, clrv: 4'h0, op: 4'd11, shmt: 4'h0, hash: 4'h0,
          src: 2'd0, jsel: 2'd0, fa: 2'd0, fb: 2'd0, rdst: 16'h0, rsrc: 16'h0,
          data: 16'h0, memv: 16'h0, wbv: 16'h0, pc: 32'h0};
    return s;
  endfunction

  // Flags are {OVF,C,N,Z}; arithmetic done with plain ints, not bit vectors.
  function automatic void ref_alu(input int op, input int a, input int b, input logic [3:0] fin,
                                  output int res, output logic [3:0] fout);
    int sa, sb, s, sh;
    logic zn;
    fout = fin; zn = 1'b1; res = 0;
    sa = (a > 32767) ? a - 65536 : a;
    sb = (b > 32767) ? b - 65536 : b;
    sh = b % 16;
    case (op)
      0: begin s = a + b; res = s % 65536; fout[2] = s > 65535;
               fout[3] = (sa + sb > 32767) || (sa + sb < -32768); end
      1: begin s = a - b; res = (s + 65536) % 65536; fout[2] = a < b;
               fout[3] = (sa - sb > 32767) || (sa - sb < -32768); end
      2: res = a & b;
      3: res = a | b;
      4: res = 65535 - a;
      5: begin s = a + 1; res = s % 65536; fout[2] = s > 65535; fout[3] = (sa + 1 > 32767); end
      6: begin res = (a + 65535) % 65536; fout[2] = (a == 0); fout[3] = (sa - 1 < -32768); end
      7: begin res = (a << sh) % 65536; if (sh != 0) fout[2] = ((a >> (16 - sh)) & 1) != 0; end
      8: begin res = a >> sh; if (sh != 0) fout[2] = ((a >> (sh - 1)) & 1) != 0; end
      9:  begin res = b; zn = 1'b0; end
      10: begin res = a; zn = 1'b0; end
      default: begin res = 0; zn = 1'b0; end
    endcase
    if (zn) begin
      fout[0] = (res == 0);
      fout[1] = (res > 32767);
    end
  endfunction

  task automatic apply(input string tag, input stim_t s);
    int a, b, res;
    logic [15:0] rs;
    logic [3:0] falu, nccr;
    logic taken;
    comb_exp_t ce;
    logic [3:0] got_ccr;
    reset = s.reset; stall = s.stall; flags_restore = s.restore; flags_restore_val = s.rval;
    {set_OVF_in, set_C_in, set_N_in, set_Z_in} = s.setv;
    {clr_OVF_in, clr_C_in, clr_N_in, clr_Z_in} = s.clrv;
    ALU_OP_in = s.op; ALU_src1_in = s.src; Shmt_in = s.shmt; hash_imm_in = s.hash;
    Rdst_val_in = s.rdst; Rsrc_val_in = s.rsrc; Data_in = s.data; PC_in = s.pc;
    is_jmp_in = s.is_jmp; jmp_sel_in = s.jsel; jmp_src_in = s.jsrc;
    a = int'(s.rdst); rs = s.rsrc;
`ifdef EX_FWD_EN
    fwd_a_sel = s.fa; fwd_b_sel = s.fb; mem_fwd_val = s.memv; wb_fwd_val = s.wbv;
    if (s.fa == 2'd1) a = int'(s.memv); else if (s.fa == 2'd2) a = int'(s.wbv);
    if (s.fb == 2'd1) rs = s.memv; else if (s.fb == 2'd2) rs = s.wbv;
`endif
    case (s.src)
      2'd0: b = int'(rs);
      2'd1: b = int'(s.data);
      2'd2: b = int'(s.hash);
      default: b = int'(s.shmt);
    endcase
    ref_alu(int'(s.op), a, b, mccr, res, falu);
    case (s.jsel)
      2'd0: taken = 1'b1;
      2'd1: taken = mccr[0];
      2'd2: taken = mccr[1];
      default: taken = mccr[2];
    endcase
    taken = taken & s.is_jmp;
    ce.res = res[15:0]; ce.taken = taken;
    ce.tgt = s.jsrc ? s.pc + 32'd1 : {16'h0, s.rdst};
    if (s.reset) nccr = 4'b0000;
    else if (s.restore) nccr = s.rval;
    else if (s.stall) nccr = mccr;
    else begin
      for (int i = 0; i < 4; i++) begin
        if (s.clrv[i]) nccr[i] = 1'b0;
        else if (s.setv[i]) nccr[i] = 1'b1;
        else if (taken && s.jsel != 2'd0 && int'(s.jsel) - 1 == i) nccr[i] = 1'b0;
        else nccr[i] = falu[i];
      end
    end
    comb_q.push_back(ce);
    ccr_q.push_back(nccr);
    #2;
    ce = comb_q.pop_front();
    check_eq({tag, ".alu_result"}, {16'h0, alu_result}, {16'h0, ce.res});
    check_eq({tag, ".jmp_taken"}, {31'h0, jmp_taken}, {31'h0, ce.taken});
    check_eq({tag, ".flush"}, {31'h0, flush}, {31'h0, ce.taken});
    check_eq({tag, ".jmp_target"}, jmp_target, ce.tgt);
    @(posedge clk); #1;
    got_ccr = ccr;
    mccr = ccr_q.pop_front();
    check_eq({tag, ".ccr"}, {28'h0, got_ccr}, {28'h0, mccr});
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    stim_t s;
    @(negedge clk);
    s = nop(); s.reset = 1'b1;                                  apply("reset", s);
    s = nop(); s.op = 4'd0; s.rdst = 16'h7FFF; s.rsrc = 16'h0001; apply("add_ovf", s);
    s = nop(); s.op = 4'd1; s.rdst = 16'h0005; s.rsrc = 16'h0005; apply("sub_zero", s);
    s = nop(); s.is_jmp = 1'b1; s.jsel = 2'd1; s.rdst = 16'h0040; apply("jz_taken", s);
    s = nop(); s.is_jmp = 1'b1; s.jsel = 2'd1; s.rdst = 16'h0040; apply("jz_not_taken", s);
    s = nop(); s.op = 4'd0; s.rdst = 16'hFFFF; s.rsrc = 16'h0001;
    s.setv = 4'b0100; s.clrv = 4'b0100;                         apply("setclr_c", s);
    s = nop(); s.op = 4'd0; s.rdst = 16'h0001; s.rsrc = 16'h0001; s.stall = 1'b1;
    s.is_jmp = 1'b1;                                            apply("stall_hold", s);
    s = nop(); s.restore = 1'b1; s.rval = 4'b1010; s.setv = 4'b0001; apply("restore", s);
    s = nop(); s.op = 4'd0; s.rdst = 16'hFFFF; s.rsrc = 16'h0001; s.reset = 1'b1;
    s.restore = 1'b1; s.rval = 4'b1111;                         apply("reset_mid", s);
    s = nop(); s.rdst = 16'h1234;                               apply("nop_hold", s);
    s = nop(); s.is_jmp = 1'b1; s.jsrc = 1'b1; s.pc = 32'hFFFF_FFFF; apply("pc_wrap", s);
    s = nop(); s.setv = 4'b0100;                                apply("set_c", s);
    s = nop(); s.op = 4'd7; s.src = 2'd3; s.shmt = 4'd0; s.rdst = 16'h0001; apply("shl0_keep_c", s);
    s = nop(); s.op = 4'd8; s.src = 2'd2; s.hash = 4'd1; s.rdst = 16'h0002; apply("shr1", s);
    s = nop(); s.op = 4'd0; s.src = 2'd1; s.data = 16'h0002; s.rdst = 16'h0010;
    s.fa = 2'd1; s.memv = 16'h0003;                             apply("fwd_a", s);
    for (int n = 0; n < 80; n++) begin
      s = nop();
      s.op = 4'($urandom_range(0, 15)); s.src = 2'($urandom);
      s.rdst = pick16(); s.rsrc = pick16(); s.data = pick16();
      s.shmt = 4'($urandom); s.hash = 4'($urandom);
      s.fa = 2'($urandom); s.fb = 2'($urandom); s.memv = pick16(); s.wbv = pick16();
      s.stall = ($urandom_range(0, 7) == 0);
      s.reset = ($urandom_range(0, 19) == 0);
      s.restore = ($urandom_range(0, 11) == 0); s.rval = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        s.setv = 4'($urandom); s.clrv = 4'($urandom);
      end
      s.is_jmp = 1'($urandom); s.jsel = 2'($urandom); s.jsrc = 1'($urandom);
      s.pc = $urandom;
      apply("rand", s);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; sampled on rising clk edge.
REQ-003 SHALL have port: stall  in  1  holds the flag register; ALU outputs stay combinational.
REQ-004 SHALL have ports from the ID/EX buffer: PC_in (32), Shmt_in (4), hash_imm_in (4), Data_in (16), Rdst_val_in (16), Rsrc_val_in (16), ALU_src1_in (2), ALU_OP_in (4), set/clr_Z/N/C/OVF_in (1 each), jmp_sel_in (2), is_jmp_in (1), jmp_src_in (1).
REQ-005 SHALL have port: flags_restore  in  1  plus flags_restore_val  in  4  popped CCR {OVF,C,N,Z} from the memory stage.
REQ-006 SHALL have port: alu_result  out  16  combinational ALU output.
REQ-007 SHALL have port: ccr  out  4  registered flags {OVF,C,N,Z}.
REQ-008 SHALL have ports: jmp_taken  out  1, jmp_target  out  32, flush  out  1; all combinational.

Function
REQ-009 Operand A SHALL be Rdst_val_in; operand B SHALL be selected by ALU_src1_in: 0 Rsrc_val_in, 1 Data_in, 2 zero-extended hash_imm_in, 3 zero-extended Shmt_in.
REQ-010 ALU_OP encoding SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 NOT A, 5 INC A, 6 DEC A, 7 SHL A by B[3:0], 8 SHR A by B[3:0], 9 pass B, 10 pass A, 11 NOP (result 0, no flag effect), 12-15 NOP.
REQ-011 Arithmetic SHALL be 17-bit internally; C = bit 16 for ADD/INC, borrow for SUB/DEC, last bit shifted out for SHL/SHR (C unchanged when shift amount is 0).
REQ-012 OVF SHALL be signed overflow for ADD/SUB/INC/DEC only; Z and N SHALL follow result for ops 0-8; ops 9-15 SHALL NOT change flags.
REQ-013 CCR next-value priority per flag, highest first: reset -> 0; flags_restore -> flags_restore_val; clr_X -> 0; set_X -> 1; taken conditional jump on X -> 0; ALU update; hold.
REQ-014 set_X and clr_X both asserted for the same flag SHALL resolve to 0.
REQ-015 stall high SHALL hold the CCR, except that reset and flags_restore still apply.
REQ-016 Conditional tests SHALL use the registered CCR, not same-cycle ALU flags.
REQ-017 jmp_sel_in SHALL select the condition: 0 always, 1 Z, 2 N, 3 C.
REQ-018 jmp_taken SHALL be is_jmp_in AND the selected condition.
REQ-019 A taken jump with jmp_sel 1..3 SHALL clear the tested flag at the next edge.
REQ-020 jmp_target SHALL be zero-extended Rdst_val_in when jmp_src_in=0 and PC_in+1 when jmp_src_in=1, with 32-bit wrap.
REQ-021 flush SHALL equal jmp_taken; stall SHALL NOT suppress it.

Reset
REQ-022 A reset cycle SHALL force ccr=4'b0000; alu_result, jmp_taken and flush SHALL then follow the inputs, which read 0 when the buffer emits its reset bubble (ALU_OP 11).
REQ-023 Reset asserted mid-operation SHALL override flags_restore, set/clr and ALU updates in that cycle.

Configuration
REQ-024 Macro EX_FWD_EN compiled in SHALL add inputs fwd_a_sel/fwd_b_sel (2 each: 0 none, 1 MEM, 2 WB, 3 none) and mem_fwd_val/wb_fwd_val (16), substituting operand A / Rsrc_val_in before the REQ-009 mux.
REQ-025 Without EX_FWD_EN, those ports SHALL be absent and operands SHALL come only from the ID/EX values.

Structure
REQ-026 The shared package SHALL hold the ALU_OP encodings, ALU_src1 encodings, jmp_sel encodings and CCR bit indices.
REQ-027 The ALU SHALL be one combinational sub-module named ex_alu; the CCR and jump logic SHALL stay in ex_stage.

Verification
REQ-028 ADD A=16'h7FFF, B=16'h0001 -> alu_result 16'h8000; next ccr OVF=1, N=1, C=0, Z=0.
REQ-029 SUB A=5, B=5 -> result 0; next ccr Z=1, C=0; then jmp_sel=1, is_jmp=1, jmp_src=0, Rdst_val=16'h0040 -> jmp_taken=1, flush=1, jmp_target 32'h40; Z=0 next cycle.
REQ-030 set_C and clr_C together with ADD carry-out -> C=0; stall=1 with ADD -> ccr unchanged.
REQ-031 flags_restore=1, value 4'b1010, with set_Z=1 -> ccr=4'b1010.
REQ-032 Reset asserted while ADD 16'hFFFF+1 is in EX -> ccr=0 next cycle; ALU_OP=11 -> alu_result=0, ccr held.
REQ-033 With EX_FWD_EN, fwd_a_sel=1, mem_fwd_val=16'h0003, B=16'h0002, ADD -> 16'h0005; without it, same vector uses Rdst_val_in.
